// File: rtl/posix_time_to_date_seq.sv
// Multi-cycle POSIX seconds to calendar date and time-of-day converter.
// Ports: clk_i/rst_n_i (async active-low), start_i + posix_time_i request,
//   busy_o/valid_o handshake, range_err_o, year/month/day/mdays/first-day,
//   weekday and hh:mm:ss result outputs (held until the next result).
// Optional macro POSIX_TZ_OFFSET_EN adds signed tz_offset_min_i (minutes).
module posix_time_to_date_seq #(
   parameter int TIME_W     = 32,
   parameter int EPOCH_YEAR = 1970,
   parameter int MAX_YEAR   = 2107,
   localparam int YEAR_W    = $clog2(MAX_YEAR + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
`ifdef POSIX_TZ_OFFSET_EN
   input  logic signed [10:0] tz_offset_min_i,
`endif
   input  logic [TIME_W-1:0] posix_time_i,
   output logic              busy_o,
   output logic              valid_o,
   output logic              range_err_o,
   output logic [YEAR_W-1:0] year_o,
   output logic [3:0]        month_o,
   output logic [4:0]        day_in_month_o,
   output logic [4:0]        month_days_cnt_o,
   output logic [2:0]        month_first_day_o,
   output logic [2:0]        weekday_o,
   output logic [4:0]        hour_o,
   output logic [5:0]        min_o,
   output logic [5:0]        sec_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_YEAR,
      S_MONTH,
      S_DAY,
      S_HOUR,
      S_MIN,
      S_DONE
   } state_t;

   localparam logic [YEAR_W-1:0] EPOCH_Y = YEAR_W'(EPOCH_YEAR);
   localparam logic [YEAR_W-1:0] LAST_Y  = YEAR_W'(MAX_YEAR - 1);
   localparam logic [6:0] EPOCH_C100 = 7'(EPOCH_YEAR % 100);
   localparam logic [8:0] EPOCH_C400 = 9'(EPOCH_YEAR % 400);
   localparam logic [2:0] EPOCH_WD   = 3'd3;

   localparam logic [TIME_W-1:0] YS_LEAP = TIME_W'(31622400);
   localparam logic [TIME_W-1:0] YS_NORM = TIME_W'(31536000);
   localparam logic [TIME_W-1:0] DAY_S   = TIME_W'(86400);
   localparam logic [TIME_W-1:0] HOUR_S  = TIME_W'(3600);
   localparam logic [TIME_W-1:0] MIN_S   = TIME_W'(60);

   function automatic logic [4:0] mdays(input logic [3:0] mo,
                                        input logic       leap);
      logic [4:0] r;
      case (mo)
         4'd1:                    r = leap ? 5'd29 : 5'd28;
         4'd3, 4'd5, 4'd8, 4'd10: r = 5'd30;
         default:                 r = 5'd31;
      endcase
      return r;
   endfunction

   function automatic logic [TIME_W-1:0] month_secs(input logic [4:0] md);
      logic [TIME_W-1:0] r;
      case (md)
         5'd28:   r = TIME_W'(2419200);
         5'd29:   r = TIME_W'(2505600);
         5'd30:   r = TIME_W'(2592000);
         default: r = TIME_W'(2678400);
      endcase
      return r;
   endfunction

   // (a + b) mod 7 for a,b in 0..6
   function automatic logic [2:0] wd_add(input logic [2:0] a,
                                         input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'd7) ? 3'(s - 4'd7) : s[2:0];
   endfunction

   state_t state_q, state_d;

   // working registers
   logic [TIME_W-1:0] rem_q, rem_d;
   logic [YEAR_W-1:0] cy_q, cy_d;
   logic [6:0]        c100_q, c100_d;
   logic [8:0]        c400_q, c400_d;
   logic [3:0]        cmo_q, cmo_d;
   logic [4:0]        cday_q, cday_d;
   logic [4:0]        chh_q, chh_d;
   logic [5:0]        cmm_q, cmm_d;
   logic [5:0]        css_q, css_d;
   logic [2:0]        cwd_q, cwd_d;
   logic [2:0]        cmfd_q, cmfd_d;
   logic              cerr_q, cerr_d;
   logic              sat_q, sat_d;

   // result registers
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [YEAR_W-1:0] year_q, year_d;
   logic [3:0]        month_q, month_d;
   logic [4:0]        mday_q, mday_d;
   logic [4:0]        mcnt_q, mcnt_d;
   logic [2:0]        mfirst_q, mfirst_d;
   logic [2:0]        wday_q, wday_d;
   logic [4:0]        hour_q, hour_d;
   logic [5:0]        min_q, min_d;
   logic [5:0]        sec_q, sec_d;

   logic              leap;
   logic [TIME_W-1:0] ys;
   logic [4:0]        md;
   logic [TIME_W-1:0] ms;
   logic [2:0]        dec1_wd;

   logic [TIME_W-1:0] start_rem;
   logic              start_err;
   logic              start_sat;

   // leap year from mod-4 bits plus mod-100/mod-400 side counters
   assign leap = ((cy_q[1:0] == 2'b00) && (c100_q != 7'd0))
               || (c400_q == 9'd0);
   assign ys   = leap ? YS_LEAP : YS_NORM;
   assign md   = mdays(cmo_q, leap);
   assign ms   = month_secs(md);
   // Dec 1 is day 334 (+1 if leap) of the year; 334 mod 7 = 5
   assign dec1_wd = wd_add(cwd_q, leap ? 3'd6 : 3'd5);

`ifdef POSIX_TZ_OFFSET_EN
   localparam logic signed [TIME_W+1:0] SIXTY = 60;
   logic signed [TIME_W+1:0] tz_ext;
   logic signed [TIME_W+1:0] adj;

   always_comb begin
      tz_ext    = {{(TIME_W + 2 - 11){tz_offset_min_i[10]}}, tz_offset_min_i};
      adj       = $signed({2'b00, posix_time_i}) + tz_ext * SIXTY;
      start_rem = adj[TIME_W-1:0];
      start_err = 1'b0;
      start_sat = 1'b0;
      if (adj[TIME_W+1]) begin
         start_rem = '0;
         start_err = 1'b1;
      end else if (adj[TIME_W]) begin
         // beyond the input range: run the year walk into saturation
         start_rem = '1;
         start_sat = 1'b1;
      end
   end
`else
   always_comb begin
      start_rem = posix_time_i;
      start_err = 1'b0;
      start_sat = 1'b0;
   end
`endif

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      cy_d     = cy_q;
      c100_d   = c100_q;
      c400_d   = c400_q;
      cmo_d    = cmo_q;
      cday_d   = cday_q;
      chh_d    = chh_q;
      cmm_d    = cmm_q;
      css_d    = css_q;
      cwd_d    = cwd_q;
      cmfd_d   = cmfd_q;
      cerr_d   = cerr_q;
      sat_d    = sat_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      year_d   = year_q;
      month_d  = month_q;
      mday_d   = mday_q;
      mcnt_d   = mcnt_q;
      mfirst_d = mfirst_q;
      wday_d   = wday_q;
      hour_d   = hour_q;
      min_d    = min_q;
      sec_d    = sec_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               rem_d   = start_rem;
               cy_d    = EPOCH_Y;
               c100_d  = EPOCH_C100;
               c400_d  = EPOCH_C400;
               cmo_d   = 4'd0;
               cday_d  = 5'd0;
               chh_d   = 5'd0;
               cmm_d   = 6'd0;
               css_d   = 6'd0;
               cwd_d   = EPOCH_WD;
               cmfd_d  = 3'd0;
               cerr_d  = start_err;
               sat_d   = start_sat;
               state_d = S_YEAR;
            end
         end
         S_YEAR: begin
            if ((rem_q >= ys) || sat_q) begin
               if (cy_q == LAST_Y) begin
                  // saturate at 23:59:59 on Dec 31 of the last year
                  cerr_d  = 1'b1;
                  cmo_d   = 4'd11;
                  cday_d  = 5'd30;
                  chh_d   = 5'd23;
                  cmm_d   = 6'd59;
                  css_d   = 6'd59;
                  cmfd_d  = dec1_wd;
                  cwd_d   = wd_add(dec1_wd, 3'd2);
                  state_d = S_DONE;
               end else begin
                  if (rem_q >= ys) begin
                     rem_d = rem_q - ys;
                  end
                  cy_d   = cy_q + YEAR_W'(1);
                  c100_d = (c100_q == 7'd99) ? 7'd0 : c100_q + 7'd1;
                  c400_d = (c400_q == 9'd399) ? 9'd0 : c400_q + 9'd1;
                  cwd_d  = wd_add(cwd_q, leap ? 3'd2 : 3'd1);
               end
            end else begin
               state_d = S_MONTH;
            end
         end
         S_MONTH: begin
            if ((rem_q >= ms) && (cmo_q != 4'd11)) begin
               rem_d = rem_q - ms;
               cmo_d = cmo_q + 4'd1;
               // month length mod 7 is (days - 28)
               cwd_d = wd_add(cwd_q, 3'(md - 5'd28));
            end else begin
               cmfd_d  = cwd_q;
               state_d = S_DAY;
            end
         end
         S_DAY: begin
            if (rem_q >= DAY_S) begin
               rem_d  = rem_q - DAY_S;
               cday_d = cday_q + 5'd1;
               cwd_d  = wd_add(cwd_q, 3'd1);
            end else begin
               state_d = S_HOUR;
            end
         end
         S_HOUR: begin
            if (rem_q >= HOUR_S) begin
               rem_d = rem_q - HOUR_S;
               chh_d = chh_q + 5'd1;
            end else begin
               state_d = S_MIN;
            end
         end
         S_MIN: begin
            if (rem_q >= MIN_S) begin
               rem_d = rem_q - MIN_S;
               cmm_d = cmm_q + 6'd1;
            end else begin
               css_d   = rem_q[5:0];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            valid_d  = 1'b1;
            err_d    = cerr_q;
            year_d   = cy_q;
            month_d  = cmo_q;
            mday_d   = cday_q;
            mcnt_d   = md;
            mfirst_d = cmfd_q;
            wday_d   = cwd_q;
            hour_d   = chh_q;
            min_d    = cmm_q;
            sec_d    = css_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         cy_q     <= EPOCH_Y;
         c100_q   <= EPOCH_C100;
         c400_q   <= EPOCH_C400;
         cmo_q    <= '0;
         cday_q   <= '0;
         chh_q    <= '0;
         cmm_q    <= '0;
         css_q    <= '0;
         cwd_q    <= '0;
         cmfd_q   <= '0;
         cerr_q   <= 1'b0;
         sat_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         year_q   <= EPOCH_Y;
         month_q  <= '0;
         mday_q   <= '0;
         mcnt_q   <= '0;
         mfirst_q <= '0;
         wday_q   <= '0;
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         cy_q     <= cy_d;
         c100_q   <= c100_d;
         c400_q   <= c400_d;
         cmo_q    <= cmo_d;
         cday_q   <= cday_d;
         chh_q    <= chh_d;
         cmm_q    <= cmm_d;
         css_q    <= css_d;
         cwd_q    <= cwd_d;
         cmfd_q   <= cmfd_d;
         cerr_q   <= cerr_d;
         sat_q    <= sat_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         year_q   <= year_d;
         month_q  <= month_d;
         mday_q   <= mday_d;
         mcnt_q   <= mcnt_d;
         mfirst_q <= mfirst_d;
         wday_q   <= wday_d;
         hour_q   <= hour_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
      end
   end

   assign busy_o            = (state_q != S_IDLE);
   assign valid_o           = valid_q;
   assign range_err_o       = err_q;
   assign year_o            = year_q;
   assign month_o           = month_q;
   assign day_in_month_o    = mday_q;
   assign month_days_cnt_o  = mcnt_q;
   assign month_first_day_o = mfirst_q;
   assign weekday_o         = wday_q;
   assign hour_o            = hour_q;
   assign min_o             = min_q;
   assign sec_o             = sec_q;

endmodule

// File: tb/tb_posix_time_to_date_seq.sv
// Bench for posix_time_to_date_seq: default instance and a MAX_YEAR=2100
// instance, checked against a day-arithmetic calendar model.
module tb_posix_time_to_date_seq;

   typedef struct {
      int year;
      int mo;
      int day;
      int mdays;
      int mfd;
      int wd;
      int hh;
      int mm;
      int ss;
      int err;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ptime = '0;
`ifdef POSIX_TZ_OFFSET_EN
   logic signed [10:0] tz_off = '0;
`endif

   logic        busy1, valid1, err1;
   logic [11:0] year1;
   logic [3:0]  mo1;
   logic [4:0]  day1, mcnt1, hh1;
   logic [2:0]  mfd1, wd1;
   logic [5:0]  mm1, ss1;

   logic        busy2, valid2, err2;
   logic [11:0] year2;
   logic [3:0]  mo2;
   logic [4:0]  day2, mcnt2, hh2;
   logic [2:0]  mfd2, wd2;
   logic [5:0]  mm2, ss2;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   posix_time_to_date_seq dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .start_i           (start),
`ifdef POSIX_TZ_OFFSET_EN
      .tz_offset_min_i   (tz_off),
`endif
      .posix_time_i      (ptime),
      .busy_o            (busy1),
      .valid_o           (valid1),
      .range_err_o       (err1),
      .year_o            (year1),
      .month_o           (mo1),
      .day_in_month_o    (day1),
      .month_days_cnt_o  (mcnt1),
      .month_first_day_o (mfd1),
      .weekday_o         (wd1),
      .hour_o            (hh1),
      .min_o             (mm1),
      .sec_o             (ss1)
   );

   posix_time_to_date_seq #(.MAX_YEAR(2100)) dut2 (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .start_i           (start),
`ifdef POSIX_TZ_OFFSET_EN
      .tz_offset_min_i   (tz_off),
`endif
      .posix_time_i      (ptime),
      .busy_o            (busy2),
      .valid_o           (valid2),
      .range_err_o       (err2),
      .year_o            (year2),
      .month_o           (mo2),
      .day_in_month_o    (day2),
      .month_days_cnt_o  (mcnt2),
      .month_first_day_o (mfd2),
      .weekday_o         (wd2),
      .hour_o            (hh2),
      .min_o             (mm2),
      .sec_o             (ss2)
   );

   function automatic bit is_leap(int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int mlen(int m, int y);
      int t[12];
      t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      return (m == 1 && is_leap(y)) ? 29 : t[m];
   endfunction

   function automatic res_t model(longint t, int maxy);
      res_t   r;
      longint days;
      longint left;
      longint secs;
      int     y;
      int     m;
      days = t / 86400;
      secs = t % 86400;
      left = days;
      y = 1970;
      while (left >= (is_leap(y) ? 366 : 365)) begin
         left -= is_leap(y) ? 366 : 365;
         y++;
      end
      if (y >= maxy) begin
         y = maxy - 1;
         days = 0;
         for (int k = 1970; k < y; k++) days += is_leap(k) ? 366 : 365;
         days += is_leap(y) ? 365 : 364;
         r.year = y;
         r.mo = 11;
         r.day = 30;
         r.mdays = 31;
         r.wd = int'((days + 3) % 7);
         r.mfd = (r.wd + 5) % 7;
         r.hh = 23;
         r.mm = 59;
         r.ss = 59;
         r.err = 1;
      end else begin
         m = 0;
         while (left >= mlen(m, y)) begin
            left -= mlen(m, y);
            m++;
         end
         r.year = y;
         r.mo = m;
         r.day = int'(left);
         r.mdays = mlen(m, y);
         r.wd = int'((days + 3) % 7);
         r.mfd = (r.wd + 7 - (r.day % 7)) % 7;
         r.hh = int'(secs / 3600);
         r.mm = int'((secs % 3600) / 60);
         r.ss = int'(secs % 60);
         r.err = 0;
      end
      return r;
   endfunction

   task automatic chk(string tag, longint obs, longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic res_t snap1();
      res_t r;
      r = '{int'(year1), int'(mo1), int'(day1), int'(mcnt1), int'(mfd1),
            int'(wd1), int'(hh1), int'(mm1), int'(ss1), int'(err1)};
      return r;
   endfunction

   function automatic res_t snap2();
      res_t r;
      r = '{int'(year2), int'(mo2), int'(day2), int'(mcnt2), int'(mfd2),
            int'(wd2), int'(hh2), int'(mm2), int'(ss2), int'(err2)};
      return r;
   endfunction

   task automatic cmp(string tag, res_t o, res_t e);
      chk({tag, ".year"}, o.year, e.year);
      chk({tag, ".month"}, o.mo, e.mo);
      chk({tag, ".day"}, o.day, e.day);
      chk({tag, ".mdays"}, o.mdays, e.mdays);
      chk({tag, ".first"}, o.mfd, e.mfd);
      chk({tag, ".wday"}, o.wd, e.wd);
      chk({tag, ".hour"}, o.hh, e.hh);
      chk({tag, ".min"}, o.mm, e.mm);
      chk({tag, ".sec"}, o.ss, e.ss);
      chk({tag, ".err"}, o.err, e.err);
   endtask

   // one conversion on both instances; optional ignored re-start at cycle 5
   task automatic convert(string tag, logic [31:0] t, bit restart);
      res_t r1, r2;
      bit   got1, got2;
      int   n, nv1, extra;
      @(negedge clk);
      start = 1'b1;
      ptime = t;
      @(negedge clk);
      start = 1'b0;
      ptime = $urandom;
      chk({tag, ".busy"}, busy1, 1);
      got1 = 0;
      got2 = 0;
      n = 0;
      nv1 = 0;
      extra = 0;
      while (extra < 3 && n < 400) begin
         start = (restart && n == 3) ? 1'b1 : 1'b0;
         if (valid1) begin
            nv1++;
            if (!got1) r1 = snap1();
            got1 = 1;
         end
         if (valid2 && !got2) begin
            r2 = snap2();
            got2 = 1;
         end
         if (got1 && got2) extra++;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      chk({tag, ".done1"}, got1, 1);
      chk({tag, ".done2"}, got2, 1);
      chk({tag, ".npulse"}, nv1, 1);
      if (got1) cmp({tag, ".a"}, r1, model(longint'(t), 2107));
      if (got2) cmp({tag, ".b"}, r2, model(longint'(t), 2100));
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, ".busy"}, busy1, 0);
      chk({tag, ".valid"}, valid1, 0);
      chk({tag, ".err"}, err1, 0);
      chk({tag, ".year"}, year1, 1970);
      chk({tag, ".month"}, mo1, 0);
      chk({tag, ".day"}, day1, 0);
      chk({tag, ".mdays"}, mcnt1, 0);
      chk({tag, ".first"}, mfd1, 0);
      chk({tag, ".wday"}, wd1, 0);
      chk({tag, ".hms"}, {hh1, mm1, ss1}, 0);
   endtask

   initial begin
      int nv;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      convert("t0", 32'd0, 0);
      convert("leap400", 32'd951782400, 0);
      convert("end2099", 32'd4102444799, 0);
      convert("y2100", 32'd4102444800, 0);
      convert("mar2100", 32'd4107542400, 0);
      convert("max", 32'hFFFF_FFFF, 0);
      convert("end1970", 32'd31535999, 0);
      convert("y1971", 32'd31536000, 0);
      convert("feb29", 32'd1709251199, 0);
      convert("restart", 32'd1234567890, 1);

      // reset asserted mid year walk
      @(negedge clk);
      start = 1'b1;
      ptime = 32'hF000_0000;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 300; i++) begin
         if (valid1 || valid2) nv++;
         @(negedge clk);
      end
      chk("midrst.novalid", nv, 0);
      convert("postrst", 32'd86399, 0);

      for (int i = 0; i < 20; i++) begin
         convert($sformatf("rnd%0d", i), $urandom, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
